// File: rtl/io_po_cko_cfg_mem_if.sv
// rtl/io_po_cko_cfg_mem_if.sv - serial config chain and live config bus for the po_cko pad tile
interface io_po_cko_cfg_mem_if #(
    parameter int MEM_WIDTH = 8
);
    logic                 ccff_head;
    logic                 shift_en;
    logic                 update_en;
    logic                 readback_en;
    logic                 ccff_tail;
    logic [MEM_WIDTH-1:0] mem_out;
    logic [MEM_WIDTH-1:0] mem_outb;
    logic                 cfg_valid;
    logic                 length_err;
    logic                 parity_err;

    modport master (
        output ccff_head,
        output shift_en,
        output update_en,
        output readback_en,
        input  ccff_tail,
        input  mem_out,
        input  mem_outb,
        input  cfg_valid,
        input  length_err,
        input  parity_err
    );

    modport slave (
        input  ccff_head,
        input  shift_en,
        input  update_en,
        input  readback_en,
        output ccff_tail,
        output mem_out,
        output mem_outb,
        output cfg_valid,
        output length_err,
        output parity_err
    );
endinterface

// File: rtl/io_po_cko_cfg_mem.sv
// rtl/io_po_cko_cfg_mem.sv - parity-checked config shift chain with shadowed live outputs for po_cko
module io_po_cko_cfg_mem #(
    parameter int MEM_WIDTH = 8,
    parameter int CNT_W     = 4
) (
    input  logic                     prog_clk,
    input  logic                     prog_reset_n,
    io_po_cko_cfg_mem_if.slave       cfg
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFTING = 2'd1,
        ARMED    = 2'd2,
        OVERRUN  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(MEM_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // sreg[MEM_WIDTH] is the parity field and also the chain tail
    logic [MEM_WIDTH:0]   sreg,         sreg_nxt;
    logic [MEM_WIDTH-1:0] shadow,       shadow_nxt;
    logic [MEM_WIDTH-1:0] shadow_b;
    logic [CNT_W-1:0]     cnt,          cnt_nxt;
    state_t               state,        state_nxt;
    logic                 cfg_valid_q,  cfg_valid_nxt;
    logic                 length_err_q, length_err_nxt;
    logic                 parity_err_q, parity_err_nxt;
    logic                 parity_ok;

    assign parity_ok = (sreg[MEM_WIDTH] == ^sreg[MEM_WIDTH-1:0]);

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            sreg         <= '0;
            shadow       <= '0;
            shadow_b     <= '1;
            cnt          <= '0;
            state        <= IDLE;
            cfg_valid_q  <= 1'b0;
            length_err_q <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            sreg         <= sreg_nxt;
            shadow       <= shadow_nxt;
            shadow_b     <= ~shadow_nxt;
            cnt          <= cnt_nxt;
            state        <= state_nxt;
            cfg_valid_q  <= cfg_valid_nxt;
            length_err_q <= length_err_nxt;
            parity_err_q <= parity_err_nxt;
        end
    end

    // Commands are mutually exclusive by priority: update, then readback, then shift.
    always_comb begin
        sreg_nxt       = sreg;
        shadow_nxt     = shadow;
        cnt_nxt        = cnt;
        cfg_valid_nxt  = cfg_valid_q;
        length_err_nxt = length_err_q;
        parity_err_nxt = parity_err_q;

        if (cfg.update_en) begin
            cnt_nxt = '0;
            if (state == ARMED && parity_ok) begin
                shadow_nxt     = sreg[MEM_WIDTH-1:0];
                cfg_valid_nxt  = 1'b1;
                length_err_nxt = 1'b0;
                parity_err_nxt = 1'b0;
            end else if (state != ARMED) begin
                length_err_nxt = 1'b1;
            end else begin
                parity_err_nxt = 1'b1;
            end
        end else if (cfg.readback_en) begin
            sreg_nxt = {^shadow, shadow};
            cnt_nxt  = '0;
        end else if (cfg.shift_en) begin
            sreg_nxt = {sreg[MEM_WIDTH-1:0], cfg.ccff_head};
            cnt_nxt  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        end
    end

    // State tracks the bit count so ARMED is a single registered decode at update time.
    always_comb begin
        state_nxt = state;
        if (cnt_nxt == '0) begin
            state_nxt = IDLE;
        end else if (cnt_nxt < FRAME_LEN) begin
            state_nxt = SHIFTING;
        end else if (cnt_nxt == FRAME_LEN) begin
            state_nxt = ARMED;
        end else begin
            state_nxt = OVERRUN;
        end
    end

    assign cfg.ccff_tail  = sreg[MEM_WIDTH];
    assign cfg.mem_out    = shadow;
    assign cfg.mem_outb   = shadow_b;
    assign cfg.cfg_valid  = cfg_valid_q;
    assign cfg.length_err = length_err_q;
    assign cfg.parity_err = parity_err_q;

endmodule
